hex4_scan_drv: RTL and testbench
================================

Name: hex4_scan_drv

Overview:
- Time-multiplexed scan driver for a 4-digit common-cathode seven-segment display.
- Holds a 16-bit hex value and presents one nibble per scan slot to the downstream hex-to-segment decoder via digit_o.
- Drives the matching one-hot digit enable an_o.
- Double-buffers the value so a display frame never tears, and inserts a dead-time blank at every digit switch to suppress ghosting.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal range 2..2^20.
- BLANK_CYC, 8, cycles at the start of each slot with an_o forced to 0; legal range 0..SCAN_DIV-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  display enable; when low an_o is held at 0, all counters keep running.
- load  input  1  single-cycle strobe; captures val_in into the pending buffer.
- val_in  input  16  hex value; nibble 0 = [3:0] = rightmost digit.
- digit_o  output  4  nibble for the current slot, fed to the segment decoder.
- an_o  output  4  one-hot digit enable, active-high; bit k lights digit k.
- frame_o  output  1  one-cycle pulse on the edge where the slot index wraps 3->0.

Behaviour:
- Reset (async, rst_n=0):
  - Prescaler=0, idx=0, blank counter=BLANK_CYC.
  - pending=0, pend_valid=0, active=0.
  - digit_o=0, an_o=0, frame_o=0.
- All outputs are registered; there is no combinational path from input to output.
- Prescaler:
  - Counts 0..SCAN_DIV-1; tick asserts in the cycle where count==SCAN_DIV-1, then count wraps to 0.
  - Counter width is clog2(SCAN_DIV).
- Slot index:
  - On the tick edge, idx <= idx+1 mod 4.
  - digit_o <= active[4*idx_next+3 : 4*idx_next] on the same edge.
  - frame_o <= 1 for that single cycle when idx_next==0, otherwise 0.
- Dead time:
  - On the tick edge the blank counter loads BLANK_CYC and an_o <= 0.
  - The counter decrements each cycle while nonzero.
  - While it is 0 and en=1, an_o = 1<<idx.
  - With BLANK_CYC=0, an_o switches directly to the new one-hot on the tick edge.
- After reset:
  - First slot is idx=0 with a dead time of BLANK_CYC cycles.
  - an_o first goes nonzero at cycle BLANK_CYC after reset release.
- Load:
  - On a clock edge with load=1: pending <= val_in, pend_valid <= 1.
  - Back-to-back loads keep only the last value.
- Commit (the tick edge where idx wraps 3->0):
  - If pend_valid: active <= pending and pend_valid <= 0.
  - digit_o on that edge uses the newly committed value.
- load and commit on the same edge:
  - Commit takes the pre-edge pending value.
  - New val_in goes to pending with pend_valid=1, and commits on the next frame.
- en:
  - en=0 forces an_o=0 on the next edge.
  - Rising en resumes an_o at the next edge unless dead time is in progress.
- Reset mid-frame: everything returns to reset values immediately; any pending value is lost.

Optional Feature:
- Macro: HEX4_LEADING_ZERO_BLANK_EN.
- When defined:
  - For slot k in 1..3, if active nibbles k..3 are all zero, an_o stays 0 for that whole slot.
  - digit_o still carries the nibble.
  - Slot 0 is never suppressed.
- When undefined: all four digits are always lit, subject to en and dead time.

Test Plan (SCAN_DIV=4, BLANK_CYC=1 unless noted):
- Reset release, no load:
  - digit_o=0 throughout; an_o = 0, then 0001 from cycle 1.
  - After 4 cycles an_o = 0 for one cycle, then 0010; pattern 0001->0010->0100->1000 repeats.
  - frame_o pulses every 16 cycles.
- load with val_in=16'h1A3F mid-frame:
  - Display is unchanged until the next frame_o.
  - Then digit_o sequences F,3,A,1 with an_o 0001,0010,0100,1000.
- load 16'h1234 then load 16'h5678 in the same frame: the next frame shows 8,7,6,5; 1234 never appears.
- load 16'hBEEF on the exact commit edge while 16'h0042 is pending:
  - The frame shows 2,4,0,0.
  - The following frame shows F,E,E,B.
- en=0 for 10 cycles:
  - an_o=0 throughout, idx keeps advancing.
  - On en=1 the lit digit matches the free-running slot.
- With HEX4_LEADING_ZERO_BLANK_EN and active=16'h0007:
  - Only the slot-0 an_o=0001 ever lights.
  - With active=16'h0000, slot 0 still lights with digit_o=0.
- rst_n pulsed low mid-slot after 16'hFFFF is committed:
  - Outputs clear immediately.
  - The display shows 0 until a new load commits.

Source files
------------

// File: rtl/hex4_scan_drv_if.sv
// Port bundle for hex4_scan_drv: display value/strobe inputs and scan outputs.
// master = the side supplying en/load/val_in; slave = the scan driver itself.
interface hex4_scan_drv_if;
  logic        en;
  logic        load;
  logic [15:0] val_in;
  logic [3:0]  digit_o;
  logic [3:0]  an_o;
  logic        frame_o;

  modport master (
    output en,
    output load,
    output val_in,
    input  digit_o,
    input  an_o,
    input  frame_o
  );

  modport slave (
    input  en,
    input  load,
    input  val_in,
    output digit_o,
    output an_o,
    output frame_o
  );
endinterface

// File: rtl/hex4_scan_drv.sv
// Four-digit seven-segment scan driver: double-buffered 16-bit value, per-slot dead time.
// Optional macro HEX4_LEADING_ZERO_BLANK_EN suppresses leading-zero digits (slots 1..3).
module hex4_scan_drv #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hex4_scan_drv_if.slave        bus
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_INIT = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q,        cnt_d;
  logic [CW-1:0] blank_q,      blank_d;
  logic [1:0]    idx_q,        idx_d;
  logic [15:0]   pend_q,       pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic [15:0]   active_q,     active_d;
  logic [3:0]    digit_q,      digit_d;
  logic [3:0]    an_q,         an_d;
  logic          frame_q,      frame_d;

  logic          tick;
  logic [1:0]    idx_nx;
  logic          lz_sup;

  always_comb begin
    tick         = (cnt_q == DIV_LAST);
    idx_nx       = idx_q + 2'd1;
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    blank_d      = blank_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    active_d     = active_q;
    digit_d      = digit_q;
    frame_d      = 1'b0;

    if (tick) begin
      idx_d   = idx_nx;
      blank_d = BLANK_INIT;
      frame_d = (idx_nx == 2'd0);
      // Commit reads the pre-edge pending value; a same-edge load refills it below.
      if ((idx_nx == 2'd0) && pend_valid_q) begin
        active_d     = pend_q;
        pend_valid_d = 1'b0;
      end
      digit_d = active_d[{idx_nx, 2'b00} +: 4];
    end else if (blank_q != '0) begin
      blank_d = blank_q - 1'b1;
    end

    if (bus.load) begin
      pend_d       = bus.val_in;
      pend_valid_d = 1'b1;
    end
  end

`ifdef HEX4_LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_sup = 1'b0;
    case (idx_d)
      2'd1:    lz_sup = (active_d[15:4]  == '0);
      2'd2:    lz_sup = (active_d[15:8]  == '0);
      2'd3:    lz_sup = (active_d[15:12] == '0);
      default: lz_sup = 1'b0;
    endcase
  end
`else
  assign lz_sup = 1'b0;
`endif

  // Enable is judged on the post-edge blank count so BLANK_CYC=0 lights on the tick edge.
  always_comb begin
    an_d = '0;
    if (bus.en && (blank_d == '0) && !lz_sup)
      an_d = 4'b0001 << idx_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      blank_q      <= BLANK_INIT;
      idx_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      active_q     <= '0;
      digit_q      <= '0;
      an_q         <= '0;
      frame_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      blank_q      <= blank_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      active_q     <= active_d;
      digit_q      <= digit_d;
      an_q         <= an_d;
      frame_q      <= frame_d;
    end
  end

  assign bus.digit_o = digit_q;
  assign bus.an_o    = an_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_hex4_scan_drv.sv
// Self-checking bench for hex4_scan_drv: directed scenarios plus random en/load traffic
// against a time-based reference model (slot and dead time derived from edge count).
module tb_hex4_scan_drv;

  localparam int unsigned D = 4;
  localparam int unsigned B = 1;

  logic clk;
  logic rst_n;
  hex4_scan_drv_if bus ();

  hex4_scan_drv #(.SCAN_DIV(D), .BLANK_CYC(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state: edges since reset release, and the two buffers.
  int unsigned n_edge;
  logic [15:0] m_pend;
  logic        m_pv;
  logic [15:0] m_act;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, obs, exp, n_edge, $time);
    end
  endtask

  task automatic model_reset();
    n_edge = 0;
    m_pend = '0;
    m_pv   = 1'b0;
    m_act  = '0;
  endtask

  task automatic model_edge(input logic en, input logic ld, input logic [15:0] v);
    n_edge++;
    if ((n_edge % (4 * D)) == 0 && m_pv) begin
      m_act = m_pend;
      m_pv  = 1'b0;
    end
    if (ld) begin
      m_pend = v;
      m_pv   = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int unsigned idx;
    int unsigned pos;
    logic [3:0]  exp_an;
    logic [3:0]  exp_dig;
    logic        sup;
    idx     = (n_edge / D) % 4;
    pos     = n_edge % D;
    exp_dig = 4'((m_act >> (4 * idx)) & 16'hF);
`ifdef HEX4_LEADING_ZERO_BLANK_EN
    sup = (idx > 0) && ((m_act >> (4 * idx)) == 0);
`else
    sup = 1'b0;
`endif
    exp_an = (bus.en && pos >= B && !sup) ? 4'(1 << idx) : 4'd0;
    check_eq("digit_o", 32'(bus.digit_o), 32'(exp_dig));
    check_eq("an_o",    32'(bus.an_o),    32'(exp_an));
    check_eq("frame_o", 32'(bus.frame_o), 32'((n_edge % (4 * D)) == 0));
  endtask

  // One clock: inputs already driven; step the model on the edge, compare #1 later.
  task automatic cycle(input logic en, input logic ld, input logic [15:0] v);
    bus.en     = en;
    bus.load   = ld;
    bus.val_in = v;
    @(posedge clk);
    model_edge(en, ld, v);
    #1;
    check_outputs();
  endtask

  task automatic run(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) cycle(1'b1, 1'b0, $urandom);
  endtask

  // Idle until the next edge is a commit edge, then perform that edge with a load.
  task automatic load_on_commit(input logic [15:0] v);
    while (((n_edge + 1) % (4 * D)) != 0) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, v);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_digit"}, 32'(bus.digit_o), 32'd0);
    check_eq({tag, "_an"},    32'(bus.an_o),    32'd0);
    check_eq({tag, "_frame"}, 32'(bus.frame_o), 32'd0);
  endtask

  initial begin
    bus.en     = 1'b1;
    bus.load   = 1'b0;
    bus.val_in = '0;
    rst_n      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // First edge after release already handled here to keep the model aligned.
    model_edge(1'b1, 1'b0, '0);
    check_outputs();

    run(40);

    // Mid-frame load becomes visible only at the next frame.
    run(5);
    cycle(1'b1, 1'b1, 16'h1A3F);
    run(40);

    // Back-to-back loads in one frame: last value wins.
    cycle(1'b1, 1'b1, 16'h1234);
    cycle(1'b1, 1'b1, 16'h5678);
    run(40);

    // Load on the commit edge while another value is pending.
    run(3);
    cycle(1'b1, 1'b1, 16'h0042);
    load_on_commit(16'hBEEF);
    run(40);

    // Display disabled for 10 cycles, counters keep running.
    for (int unsigned i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0);
    run(20);

    // Leading-zero-style values and zero.
    load_on_commit(16'h0007);
    run(40);
    load_on_commit(16'h0000);
    run(40);

    // Random traffic.
    for (int unsigned i = 0; i < 800; i++) begin
      logic en_r;
      logic ld_r;
      en_r = ($urandom_range(0, 9) != 0);
      ld_r = ($urandom_range(0, 11) == 0);
      cycle(en_r, ld_r, 16'($urandom));
    end

    // Reset mid-slot after FFFF committed, with a value still pending.
    load_on_commit(16'hFFFF);
    run(6);
    cycle(1'b1, 1'b1, 16'h9C9C);
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.load = 1'b0;
    @(posedge clk);
    #1;
    model_edge(1'b1, 1'b0, '0);
    check_outputs();
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
